freq_meter: RTL
===============

Name: freq_meter

Overview:
- Reciprocal of the clock/strobe divider: counts rising edges of an asynchronous external signal over a fixed gate window of system-clock cycles.
- Publishes the count as a frequency result for the VGA readout logic.
- Sits beside the divider on the 100 MHz system clock.
- The default gate of 1 s gives the result directly in Hz.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency (documentation/derivation only).
- GATE_CYCLES, 100_000_000, gate window length in clk cycles (≥2); the bench overrides it to 1000.
- CNT_W, 32, width of the edge counter and result.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high.
- sig_in  in  1  measured signal, asynchronous to clk.
- en  in  1  level enable; high = run back-to-back gate windows.
- freq_cnt  out  CNT_W  edge count of last completed window.
- freq_valid  out  1  one-cycle pulse when freq_cnt is updated.
- overflow  out  1  last completed window saturated the counter.
- busy  out  1  gate window in progress.

Behaviour:
- Reset: rst_n is asynchronous, active-high; clock is clk.
  - While rst_n=1: synchronizer flops, edge counter, gate counter, freq_cnt, freq_valid, overflow and busy are all 0, and the FSM is in IDLE.
- Input path:
  - 2-flop synchronizer s1, s2, then delay flop s3.
  - rise = s2 & ~s3.
  - A sig_in transition reaches rise 3 clk later. This latency is constant, so no edges are lost between windows.
  - Guaranteed detection requires sig_in high and low phases each ≥2 clk, i.e. f ≤ CLK_HZ/4.
- FSM states: IDLE, GATE.
- IDLE:
  - busy=0; counters held at 0.
  - en=1 → GATE next cycle with gate_cnt=0, edge_cnt=0.
- GATE:
  - busy=1.
  - gate_cnt increments 0..GATE_CYCLES-1.
  - edge_cnt increments on each rise cycle. It saturates at 2^CNT_W-1 and sets an internal ovf flag.
- End of window (gate_cnt==GATE_CYCLES-1):
  - A rise in this final cycle counts toward the current window.
  - Next clk edge: freq_cnt ← final count, overflow ← ovf, freq_valid=1 for exactly one cycle.
  - Window length is exactly GATE_CYCLES cycles.
- Continuous operation: if en=1 at the final cycle, the next window starts immediately with no dead cycle.
  - gate_cnt=0; edge_cnt=0; ovf=0.
  - A rise in the first cycle of the new window counts toward the new window.
  - freq_valid pulses therefore repeat every GATE_CYCLES cycles.
- If en=0 at the final cycle: the result is still published, then the FSM goes to IDLE.
- en dropped mid-window (before the final cycle): abort.
  - GATE → IDLE next cycle; busy=0.
  - No freq_valid; freq_cnt and overflow keep their previous values.
- freq_cnt and overflow hold between updates; they are never cleared except by reset.
- Reset asserted mid-window: immediate clear; no partial result is published.

Test Plan:
- Reset: assert rst_n=1 for 5 cycles with sig_in toggling → freq_cnt=0, freq_valid=0, overflow=0, busy=0 throughout.
- GATE_CYCLES=1000, sig_in period 10 clk (5 high/5 low), en=1 → first freq_valid 1000 cycles after busy rises, freq_cnt=100, overflow=0.
- Continuous run, same stimulus → three freq_valid pulses spaced exactly 1000 cycles apart, each with freq_cnt=100; busy stays 1 between them.
- sig_in held 0, en=1 → freq_valid pulses, freq_cnt=0; then sig_in period 4 → next window freq_cnt=250.
- CNT_W=4, sig_in period 10 → freq_cnt=15, overflow=1; then sig_in period 100 → next window freq_cnt=10, overflow=0.
- After a result of 100, drop en at gate_cnt=500 → busy=0 next cycle, no freq_valid, freq_cnt stays 100; re-raise en → fresh full 1000-cycle window.

Source files
------------

// File: rtl/freq_meter_if.sv
// Signal bundle between the frequency meter and its consumer (stimulus + VGA readout).
// The master side drives the measured signal and enable; the slave side is the meter.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             sig_in;
  logic             en;
  logic [CNT_W-1:0] freq_cnt;
  logic             freq_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output sig_in,
    output en,
    input  freq_cnt,
    input  freq_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  sig_in,
    input  en,
    output freq_cnt,
    output freq_valid,
    output overflow,
    output busy
  );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous signal over GATE_CYCLES clk cycles
// and publishes the count (saturating at 2^CNT_W-1) once per completed window.
module freq_meter #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input logic         clk,
  input logic         rst_n,
  freq_meter_if.slave bus_io
);

  localparam int unsigned      GateW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  if (GATE_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
    $error("freq_meter: GATE_CYCLES must be >= 2 and CLK_HZ non-zero");
  end

  typedef enum logic [0:0] {StIdle, StGate} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [GateW-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_sum;
  logic             ovf_q, ovf_d, ovf_sum;
  logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
  logic             overflow_q, overflow_d;
  logic             freq_valid_q, freq_valid_d;
  logic             rise, busy, last;

  // Fixed 3-cycle path from sig_in to rise, so window boundaries never drop an edge.
  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_io.en) state_d = StGate;
      StGate:  if (!bus_io.en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StGate);
    last = busy && (gate_cnt_q == GateLast);
  end

  always_comb begin
    edge_sum = edge_cnt_q;
    ovf_sum  = ovf_q;
    if (rise) begin
      if (edge_cnt_q == CntMax) ovf_sum = 1'b1;
      else                      edge_sum = edge_cnt_q + 1'b1;
    end
    // Counters restart at zero on idle, abort and window rollover alike.
    gate_cnt_d = '0;
    edge_cnt_d = '0;
    ovf_d      = 1'b0;
    if (busy && !last && bus_io.en) begin
      gate_cnt_d = gate_cnt_q + 1'b1;
      edge_cnt_d = edge_sum;
      ovf_d      = ovf_sum;
    end
    freq_cnt_d   = last ? edge_sum : freq_cnt_q;
    overflow_d   = last ? ovf_sum : overflow_q;
    freq_valid_d = last;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      freq_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      s1_q         <= bus_io.sig_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_q        <= ovf_d;
      freq_cnt_q   <= freq_cnt_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign bus_io.freq_cnt   = freq_cnt_q;
  assign bus_io.freq_valid = freq_valid_q;
  assign bus_io.overflow   = overflow_q;
  assign bus_io.busy       = busy;

endmodule
